// File: rtl/mips32_prog_loader_if.sv
// mips32_prog_loader_if: byte-stream input and Mem write port of the program loader
interface mips32_prog_loader_if #(parameter int ADDR_W = 10);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    modport master (input byte_valid, byte_data, output byte_ready, mem_we, mem_addr, mem_wdata);
    modport slave  (output byte_valid, byte_data, input byte_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/mips32_prog_loader.sv
// mips32_prog_loader: packs a checksummed byte-stream program image into core Mem, then releases the core
module mips32_prog_loader #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 1024
) (
    input  logic                clk1,
    input  logic                rst_n,
    input  logic                start,
    mips32_prog_loader_if.master bus,
    output logic                core_run,
    output logic                done,
    output logic                error,
    output logic [15:0]         word_count
);
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR} state_t;
    localparam logic [16:0] MAXW = 17'(MAX_WORDS);
    state_t      state, state_nx;
    logic [15:0] len;
    logic [23:0] shreg;
    logic [7:0]  csum;
    logic [1:0]  byte_idx;
    logic        xfer, go, last;
    assign bus.byte_ready = state inside {LEN_HI, LEN_LO, DATA, CSUM};
    assign xfer = bus.byte_valid & bus.byte_ready;
    assign go   = start & (state inside {IDLE, DONE, ERROR});
    // word_count already counts every earlier word when a word's 4th byte arrives
    assign last = byte_idx == 2'd3 && word_count + 16'd1 == len;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERROR: state_nx = go ? LEN_HI : state;
            LEN_HI: state_nx = xfer ? LEN_LO : state;
            LEN_LO: if (xfer) state_nx = {len[15:8], bus.byte_data} == 16'd0 ? CSUM :
                                         {1'b0, len[15:8], bus.byte_data} > MAXW ? ERROR : DATA;
            DATA:   if (xfer && last) state_nx = CSUM;
            CSUM:   if (xfer) state_nx = csum == bus.byte_data ? DONE : ERROR;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk1 or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            core_run      <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            word_count    <= '0;
            len           <= '0;
            shreg         <= '0;
            csum          <= '0;
            byte_idx      <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            done       <= state_nx == DONE;
            core_run   <= state_nx == DONE;
            error      <= state_nx == ERROR;
            if (go) begin
                word_count <= '0;
                csum       <= '0;
                byte_idx   <= '0;
            end
            if (xfer && state == LEN_HI) len[15:8] <= bus.byte_data;
            if (xfer && state == LEN_LO) len[7:0] <= bus.byte_data;
            if (xfer && state == DATA) begin
                shreg    <= {shreg[15:0], bus.byte_data};
                csum     <= csum ^ bus.byte_data;
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    bus.mem_we    <= 1'b1;
                    bus.mem_wdata <= {shreg, bus.byte_data};
                    bus.mem_addr  <= BASE_ADDR + word_count[ADDR_W-1:0];
                    word_count    <= word_count + 16'd1;
                end
            end
        end
    end
endmodule
